// File: rtl/tone_level_generator_if.sv
// ---------------------------------------------------------------------------
// tone_level_generator_if
//   Groups the control inputs and the valid/ready sample stream of the tone
//   level generator.
//   Signals:
//     enable        1       1 = generate tone; 0 = stop after the pending sample
//     level         3       requested volume band 0..5; 6/7 = mute
//     sample_ready  1       sink accepts sample_data this cycle
//     sample_valid  1       sample_data holds a valid sample
//     sample_data   DATA_W  signed two's complement sample
//     cur_level     3       level latched for the current half-cycle
//   Modports:
//     master  - the generator (drives the sample stream)
//     slave   - the controlling / sinking side
// ---------------------------------------------------------------------------
interface tone_level_generator_if #(
  parameter int DATA_W = 24
);
  logic                     enable;
  logic [2:0]               level;
  logic                     sample_ready;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample_data;
  logic [2:0]               cur_level;

  modport master (
    input  enable,
    input  level,
    input  sample_ready,
    output sample_valid,
    output sample_data,
    output cur_level
  );

  modport slave (
    output enable,
    output level,
    output sample_ready,
    input  sample_valid,
    input  sample_data,
    input  cur_level
  );
endinterface

// File: rtl/tone_level_generator.sv
// ---------------------------------------------------------------------------
// tone_level_generator
//   Synthesises a signed square-wave test tone whose peak magnitude sits in
//   the middle of a selected volume band (level 0..5) of the volume meter, and
//   streams it toward the codec writer over valid/ready.
//   Ports:
//     clk_select  in  single clock, all state on the rising edge
//     reset       in  asynchronous, active-low reset
//     tone        master modport of tone_level_generator_if
//                 (enable, level, sample_ready in; sample_valid, sample_data,
//                  cur_level out)
//   Configuration macro:
//     TONE_SWEEP_EN - when defined the level input is ignored and the level
//                     sweeps 0..5 once per full tone period, restarting at 0
//                     each time the tone starts from idle.
// ---------------------------------------------------------------------------
module tone_level_generator #(
  parameter int DATA_W      = 24,
  parameter int HALF_PERIOD = 54,
  parameter int LEVEL_STEP  = 100000,
  parameter int AMP_OFFSET  = 50000
) (
  input  logic                   clk_select,
  input  logic                   reset,
  tone_level_generator_if.master tone
);

  localparam int CNT_W = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POS  = 2'd1,
    S_NEG  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     valid_q, valid_d;
  logic signed [DATA_W-1:0] data_q,  data_d;
  logic [2:0]               lvl_q,   lvl_d;

  logic                     xfer;
  logic [2:0]               lvl_bound;   // level to latch at the next boundary

  // Amplitude per level; levels 6/7 are mute.
  logic signed [DATA_W-1:0] amp_tbl [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_amp
      if (gi < 6) begin : g_band
        assign amp_tbl[gi] = DATA_W'((gi + 1) * LEVEL_STEP + AMP_OFFSET);
      end else begin : g_mute
        assign amp_tbl[gi] = '0;
      end
    end
  endgenerate

  assign xfer = valid_q & tone.sample_ready;

`ifdef TONE_SWEEP_EN
  // Sweep: restart at 0 from idle, advance on NEG->POS, hold on POS->NEG.
  always_comb begin
    lvl_bound = lvl_q;
    if (state_q == S_IDLE) begin
      lvl_bound = 3'd0;
    end else if (state_q == S_NEG) begin
      lvl_bound = (lvl_q >= 3'd5) ? 3'd0 : lvl_q + 3'd1;
    end
  end
`else
  assign lvl_bound = tone.level;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    valid_d = valid_q;
    data_d  = data_q;
    lvl_d   = lvl_q;
    case (state_q)
      S_IDLE: begin
        if (tone.enable) begin
          state_d = S_POS;
          valid_d = 1'b1;
          count_d = '0;
          lvl_d   = lvl_bound;
          data_d  = amp_tbl[lvl_bound];
        end
      end
      default: begin
        if (xfer) begin
          // Stopping wins over a half-cycle boundary on the same transfer.
          if (!tone.enable) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            count_d = '0;
          end else if (count_q == CNT_LAST) begin
            count_d = '0;
            lvl_d   = lvl_bound;
            if (state_q == S_POS) begin
              state_d = S_NEG;
              data_d  = -amp_tbl[lvl_bound];
            end else begin
              state_d = S_POS;
              data_d  = amp_tbl[lvl_bound];
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_select or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      lvl_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      lvl_q   <= lvl_d;
    end
  end

  assign tone.sample_valid = valid_q;
  assign tone.sample_data  = data_q;
  assign tone.cur_level    = lvl_q;

endmodule

// File: tb/tb_tone_level_generator.sv
// ---------------------------------------------------------------------------
// tb_tone_level_generator
//   Directed bench for tone_level_generator with HALF_PERIOD=4. Inputs change
//   and outputs are sampled 1 time unit after each rising edge.
//   With TONE_SWEEP_EN defined only the sweep sequence is run.
// ---------------------------------------------------------------------------
module tb_tone_level_generator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  tone_level_generator_if #(.DATA_W(24)) tb_if ();

  tone_level_generator #(
    .DATA_W      (24),
    .HALF_PERIOD (4),
    .LEVEL_STEP  (100000),
    .AMP_OFFSET  (50000)
  ) dut (
    .clk_select (clk),
    .reset      (rst_n),
    .tone       (tb_if)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the presented sample, then let the edge transfer it (ready must be 1).
  task automatic expect_sample(input string tag, input int exp_data, input int exp_lvl);
    int d;
    d = tb_if.sample_data;
    check_eq({tag, ".valid"}, int'(tb_if.sample_valid), 1);
    check_eq({tag, ".data"},  d, exp_data);
    check_eq({tag, ".lvl"},   int'(tb_if.cur_level), exp_lvl);
    $display("xfer %s data=%0d cur_level=%0d", tag, d, tb_if.cur_level);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tb_if.enable = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    tb_if.enable       = 1'b0;
    tb_if.level        = 3'd0;
    tb_if.sample_ready = 1'b1;
    tick();
    d = tb_if.sample_data;
    check_eq("rst.valid", int'(tb_if.sample_valid), 0);
    check_eq("rst.data",  d, 0);
    check_eq("rst.lvl",   int'(tb_if.cur_level), 0);
    rst_n = 1'b1;

`ifdef TONE_SWEEP_EN
    begin
      int amp_tbl [6] = '{150000, 250000, 350000, 450000, 550000, 650000};
      tb_if.level  = 3'd7;
      tb_if.enable = 1'b1;
      tick();
      for (int p = 0; p < 7; p++) begin
        for (int i = 0; i < 4; i++) expect_sample("sw.pos", amp_tbl[p % 6], p % 6);
        for (int i = 0; i < 4; i++) expect_sample("sw.neg", -amp_tbl[p % 6], p % 6);
      end
    end
`else
    // 1: level 0, one-cycle latency, two full periods.
    tick();
    tb_if.enable = 1'b1;
    check_eq("t1.pre_valid", int'(tb_if.sample_valid), 0);
    tick();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) expect_sample("t1.pos", 150000, 0);
      for (int i = 0; i < 4; i++) expect_sample("t1.neg", -150000, 0);
    end

    // 2: level 5, then mute at the next boundary.
    do_reset();
    tb_if.level  = 3'd5;
    tb_if.enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) expect_sample("t2.pos", 650000, 5);
    for (int i = 0; i < 3; i++) expect_sample("t2.neg", -650000, 5);
    tb_if.level = 3'd7;
    expect_sample("t2.neg", -650000, 5);
    for (int i = 0; i < 8; i++) expect_sample("t2.mute", 0, 7);

    // 3: backpressure after two POS transfers.
    do_reset();
    tb_if.level  = 3'd2;
    tb_if.enable = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) expect_sample("t3.pos", 350000, 2);
    tb_if.sample_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d = tb_if.sample_data;
      check_eq("t3.stall.valid", int'(tb_if.sample_valid), 1);
      check_eq("t3.stall.data",  d, 350000);
      tick();
    end
    tb_if.sample_ready = 1'b1;
    for (int i = 0; i < 2; i++) expect_sample("t3.pos", 350000, 2);
    expect_sample("t3.neg", -350000, 2);

    // 4: level change mid-half only applies at the boundary.
    do_reset();
    tb_if.level  = 3'd1;
    tb_if.enable = 1'b1;
    tick();
    expect_sample("t4.pos", 250000, 1);
    tb_if.level = 3'd3;
    for (int i = 0; i < 3; i++) expect_sample("t4.pos", 250000, 1);
    for (int i = 0; i < 4; i++) expect_sample("t4.neg", -450000, 3);

    // 5: stop with backpressure, then async reset mid-NEG.
    do_reset();
    tb_if.level  = 3'd4;
    tb_if.enable = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) expect_sample("t5.pos", 550000, 4);
    tb_if.sample_ready = 1'b0;
    tb_if.enable       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = tb_if.sample_data;
      check_eq("t5.hold.valid", int'(tb_if.sample_valid), 1);
      check_eq("t5.hold.data",  d, 550000);
      tick();
    end
    tb_if.sample_ready = 1'b1;
    expect_sample("t5.last", 550000, 4);
    check_eq("t5.stop.valid", int'(tb_if.sample_valid), 0);
    tick();
    check_eq("t5.idle.valid", int'(tb_if.sample_valid), 0);
    tb_if.enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) expect_sample("t5.pos", 550000, 4);
    for (int i = 0; i < 2; i++) expect_sample("t5.neg", -550000, 4);
    rst_n = 1'b0;
    #1;
    d = tb_if.sample_data;
    check_eq("t5.arst.valid", int'(tb_if.sample_valid), 0);
    check_eq("t5.arst.data",  d, 0);
    check_eq("t5.arst.lvl",   int'(tb_if.cur_level), 0);
    tick();
    check_eq("t5.arst.hold", int'(tb_if.sample_valid), 0);
    tb_if.enable = 1'b0;
    rst_n = 1'b1;
    tick();
    check_eq("t5.post.valid", int'(tb_if.sample_valid), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
